// File: rtl/stream_pkg.sv
// Shared types and defaults for the stream fork and its output skid slices.
//   slice_state_t : occupancy of a 2-entry skid slice (EMPTY, ONE, TWO)
//   DEF_D_WIDTH   : default data word width
package stream_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } slice_state_t;

  localparam int unsigned DEF_D_WIDTH = 6;

  // Slice may accept a new word only while it has a free entry.
  function automatic logic slice_has_room(input slice_state_t st);
    return st != TWO;
  endfunction

  // Slice presents a word whenever it holds at least one entry.
  function automatic logic slice_has_data(input slice_state_t st);
    return st != EMPTY;
  endfunction

endpackage

// File: rtl/stream_reg_slice.sv
// Two-entry skid slice: registered valid/data/ready on a valid/ready stream.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   i_data/i_valid upstream word and valid
//   o_ready        upstream ready (registered: state != TWO)
//   o_data/o_valid downstream word (head entry) and valid
//   i_ready        downstream ready
// Words leave in arrival order; r_d0 always holds the head entry.
module stream_reg_slice
  import stream_pkg::*;
#(
  parameter int unsigned D_WIDTH = DEF_D_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [D_WIDTH-1:0] i_data,
  input  logic               i_valid,
  output logic               o_ready,
  output logic [D_WIDTH-1:0] o_data,
  output logic               o_valid,
  input  logic               i_ready
);

  slice_state_t       r_state;
  slice_state_t       w_state_nxt;
  logic [D_WIDTH-1:0] r_d0;
  logic [D_WIDTH-1:0] r_d1;
  logic [D_WIDTH-1:0] w_d0_nxt;
  logic [D_WIDTH-1:0] w_d1_nxt;
  logic               w_push;
  logic               w_pop;

  assign o_ready = slice_has_room(r_state);
  assign o_valid = slice_has_data(r_state);
  assign o_data  = r_d0;

  assign w_push = i_valid & o_ready;
  assign w_pop  = o_valid & i_ready;

  // State and storage registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= EMPTY;
      r_d0    <= '0;
      r_d1    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_d0    <= w_d0_nxt;
      r_d1    <= w_d1_nxt;
    end
  end

  // Next-state and storage update.
  always_comb begin
    w_state_nxt = r_state;
    w_d0_nxt    = r_d0;
    w_d1_nxt    = r_d1;
    unique case (r_state)
      EMPTY: begin
        if (w_push) begin
          w_state_nxt = ONE;
          w_d0_nxt    = i_data;
        end
      end
      ONE: begin
        if (w_push && w_pop) begin
          // Head leaves, new word becomes head in the same cycle.
          w_d0_nxt = i_data;
        end else if (w_push) begin
          w_state_nxt = TWO;
          w_d1_nxt    = i_data;
        end else if (w_pop) begin
          w_state_nxt = EMPTY;
        end
      end
      TWO: begin
        // No push possible here: o_ready is low while full.
        if (w_pop) begin
          w_state_nxt = ONE;
          w_d0_nxt    = r_d1;
        end
      end
      default: begin
        w_state_nxt = EMPTY;
      end
    endcase
  end

endmodule

// File: rtl/stream_fork_bcast.sv
// Broadcast fork: delivers every upstream word exactly once to branch A and B.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   up_data/up_valid/up_ready     upstream stream
//   down_data_a/_valid_a/_ready_a branch A stream
//   down_data_b/_valid_b/_ready_b branch B stream
// Build option FORK_REG_SLICE_EN: adds a 2-entry skid slice on each branch
// output so up_ready depends only on registered state. Without it the branch
// outputs are driven straight from the fork core.
module stream_fork_bcast
  import stream_pkg::*;
#(
  parameter int unsigned D_WIDTH = DEF_D_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [D_WIDTH-1:0] up_data,
  input  logic               up_valid,
  output logic               up_ready,
  output logic [D_WIDTH-1:0] down_data_a,
  output logic               down_valid_a,
  input  logic               down_ready_a,
  output logic [D_WIDTH-1:0] down_data_b,
  output logic               down_valid_b,
  input  logic               down_ready_b
);

  logic r_done_a;
  logic r_done_b;
  logic w_cv_a;
  logic w_cv_b;
  logic w_cr_a;
  logic w_cr_b;
  logic w_retire;

  // Core branch valid; gated by rst so outputs drop as soon as reset asserts.
  assign w_cv_a = rst & up_valid & ~r_done_a;
  assign w_cv_b = rst & up_valid & ~r_done_b;

  // The word retires once each branch has either taken it or takes it now.
  assign up_ready = rst & (w_cr_a | r_done_a) & (w_cr_b | r_done_b);
  assign w_retire = up_valid & up_ready;

  // Per-branch delivery flags for the word currently held upstream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_done_a <= 1'b0;
      r_done_b <= 1'b0;
    end else if (w_retire) begin
      r_done_a <= 1'b0;
      r_done_b <= 1'b0;
    end else begin
      r_done_a <= r_done_a | (w_cv_a & w_cr_a);
      r_done_b <= r_done_b | (w_cv_b & w_cr_b);
    end
  end

`ifdef FORK_REG_SLICE_EN
  stream_reg_slice #(
    .D_WIDTH (D_WIDTH)
  ) u_slice_a (
    .clk     (clk),
    .rst     (rst),
    .i_data  (up_data),
    .i_valid (w_cv_a),
    .o_ready (w_cr_a),
    .o_data  (down_data_a),
    .o_valid (down_valid_a),
    .i_ready (down_ready_a)
  );

  stream_reg_slice #(
    .D_WIDTH (D_WIDTH)
  ) u_slice_b (
    .clk     (clk),
    .rst     (rst),
    .i_data  (up_data),
    .i_valid (w_cv_b),
    .o_ready (w_cr_b),
    .o_data  (down_data_b),
    .o_valid (down_valid_b),
    .i_ready (down_ready_b)
  );
`else
  // Direct drive: zero latency, branch ready feeds the core combinationally.
  assign w_cr_a       = down_ready_a;
  assign w_cr_b       = down_ready_b;
  assign down_valid_a = w_cv_a;
  assign down_valid_b = w_cv_b;
  assign down_data_a  = up_data;
  assign down_data_b  = up_data;
`endif

endmodule
